// File: rtl/led_ser_pkg.sv
// Shared types and helpers for the LED bit serializer: FSM state encoding and
// a clog2 variant that never returns zero, so single-value fields keep one bit.
package led_ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_GAP
   } state_e;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter shared by the SHOW and GAP phases. tc marks the final
// cycle of a phase; tc_pre marks the cycle before it, for one-cycle lookahead.
module period_timer #(
   parameter int CW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tc,
   output logic          tc_pre
);

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: combinational blocks assign every output a default first, so no path leaves a value held (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   assign tc     = (cnt_q == '0);
   assign tc_pre = (cnt_q == CW'(1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_bit_serializer.sv
// Plays a latched WIDTH-bit word out on one LED, one bit per INTERVAL cycles
// with an optional GAP-cycle low blank after each bit; supports loop and abort.
module led_bit_serializer
   import led_ser_pkg::*;
#(
   parameter  int WIDTH    = 64,
   parameter  int INTERVAL = 1250,
   parameter  int GAP      = 0,
   localparam int IW       = clog2_min1(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             msb_first,
   input  logic             loop_en,
   input  logic [WIDTH-1:0] data,
   output logic             led,
   output logic             busy,
   output logic             done,
   output logic             bit_strobe,
   output logic [IW-1:0]    bit_idx
);

   localparam int            CW         = clog2_min1((INTERVAL > GAP) ? INTERVAL : GAP);
   localparam logic [CW-1:0] SHOW_LOAD  = CW'(INTERVAL - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [IW-1:0] TOP_IDX    = IW'(WIDTH - 1);
   localparam state_e        LAST_PHASE = (GAP > 0) ? ST_GAP : ST_SHOW;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             msb_q, msb_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             led_q, led_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             strobe_q, strobe_d;

   logic          load;
   logic [CW-1:0] load_val;
   logic          tc, tc_pre;
   logic          advance, nxt_tc, frame_end;
   logic [IW-1:0] first_idx, last_idx, last_idx_d;

   period_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .tc       (tc),
      .tc_pre   (tc_pre)
   );

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      msb_d      = msb_q;
      idx_d      = idx_q;
      load       = 1'b0;
      load_val   = SHOW_LOAD;
      advance    = 1'b0;
      done_d     = 1'b0;
      first_idx  = msb_q ? TOP_IDX : '0;
      last_idx   = msb_q ? '0 : TOP_IDX;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               word_d  = data;
               msb_d   = msb_first;
               idx_d   = msb_first ? TOP_IDX : '0;
               state_d = ST_SHOW;
               load    = 1'b1;
            end
         end
         ST_SHOW: begin
            if (tc) begin
               if (GAP > 0) begin
                  state_d  = ST_GAP;
                  load     = 1'b1;
                  load_val = GAP_LOAD;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (tc) advance = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Past the last bit the index wraps to the first one, ready for loop mode.
      if (advance) begin
         if (idx_q == last_idx) idx_d = first_idx;
         else                   idx_d = msb_q ? idx_q - IW'(1) : idx_q + IW'(1);
         state_d  = ST_SHOW;
         load     = 1'b1;
         load_val = SHOW_LOAD;
      end

      // The final cycle of a non-looping frame is the done cycle, shown from IDLE.
      last_idx_d = msb_d ? '0 : TOP_IDX;
      nxt_tc     = load ? (load_val == '0) : tc_pre;
      frame_end  = (state_d == LAST_PHASE) && (idx_d == last_idx_d) && nxt_tc;

      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else if (frame_end && !loop_en) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
      end

      led_d    = (state_d == ST_SHOW) ? word_d[idx_d] : 1'b0;
      busy_d   = (state_d != ST_IDLE);
      strobe_d = (state_d == ST_SHOW) && load;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         word_q   <= '0;
         msb_q    <= 1'b0;
         idx_q    <= '0;
         led_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         msb_q    <= msb_d;
         idx_q    <= idx_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         strobe_q <= strobe_d;
      end
   end

   assign led        = led_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign bit_strobe = strobe_q;
   assign bit_idx    = idx_q;

endmodule
